// File: rtl/chrisruk_digit_feeder.sv
// Serial ASCII digit receiver, 8N1 over rx, feeding a 4-entry FIFO that is popped one glyph per digit_req.
// Pushes land on the stop-sample edge; pops update digit on the same edge; optional err_count behind FEEDER_ERR_COUNT_EN.
module chrisruk_digit_feeder #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       digit_req,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic [2:0] fifo_level,
  output logic       overflow
`ifdef FEEDER_ERR_COUNT_EN
  ,
  output logic [3:0] err_count
`endif
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            rx_meta;
  logic            rxs;

  logic [3:0]      mem [4];
  logic [1:0]      wr_ptr;
  logic [1:0]      rd_ptr;

  logic            stop_smp;
  logic            good_byte;
  logic            push_cmd;
  logic            clr_cmd;
  logic            pop_ok;
  logic            push_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_smp  = (state == STOP) && (cnt == CW'(CLKS_PER_BIT - 1));
  assign good_byte = stop_smp && rxs;
  assign push_cmd  = good_byte && (shreg >= 8'h30) && (shreg <= 8'h39);
  assign clr_cmd   = good_byte && (shreg == 8'h23);

  // Clear beats pop; a full FIFO still accepts a push when a pop frees a slot the same edge.
  assign pop_ok  = digit_req && (fifo_level != 3'd0) && !clr_cmd;
  assign push_ok = push_cmd && ((fifo_level != 3'd4) || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg[3:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      digit       <= '0;
      digit_valid <= 1'b0;
    end else begin
      digit_valid <= pop_ok;
      if (clr_cmd) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        overflow   <= 1'b0;
      end else begin
        if (pop_ok) begin
          digit  <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 2'd1;
        end
        if (push_ok) wr_ptr <= wr_ptr + 2'd1;
        if (push_cmd && !push_ok) overflow <= 1'b1;
        case ({push_ok, pop_ok})
          2'b10:   fifo_level <= fifo_level + 3'd1;
          2'b01:   fifo_level <= fifo_level - 3'd1;
          default: fifo_level <= fifo_level;
        endcase
      end
    end
  end

`ifdef FEEDER_ERR_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (stop_smp && !rxs && (err_count != 4'd15)) begin
      err_count <= err_count + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chrisruk_digit_feeder.sv
// Randomised and directed bench for chrisruk_digit_feeder against a queue-based model of the byte filter and FIFO.
module tb_chrisruk_digit_feeder;

  localparam int CPB = 4;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic       digit_req;
  logic [3:0] digit;
  logic       digit_valid;
  logic [2:0] fifo_level;
  logic       overflow;
`ifdef FEEDER_ERR_COUNT_EN
  logic [3:0] err_count;
`endif

  chrisruk_digit_feeder #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .digit_req   (digit_req),
    .digit       (digit),
    .digit_valid (digit_valid),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
`ifdef FEEDER_ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: transaction-level view of what the feeder should hold.
  int m_q[$];
  int m_ovf;
  int m_errs;
  int m_digit;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 0;
    m_errs  = 0;
    m_digit = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".level"}, int'(fifo_level), m_q.size());
    check({tag, ".ovf"}, int'(overflow), m_ovf);
`ifdef FEEDER_ERR_COUNT_EN
    check({tag, ".err"}, int'(err_count), m_errs);
`endif
  endtask

  // Called at a negedge; returns at a negedge after the frame has settled.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit req_at_stop);
    logic [9:0] frame;
    bit good, is_clr, is_dig, exp_pop;
    frame = {~bad_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    // Next posedge is the stop-sample edge.
    rx        = 1'b1;
    digit_req = req_at_stop;
    good   = !bad_stop;
    is_clr = good && (b == 8'h23);
    is_dig = good && (b >= 8'h30) && (b <= 8'h39);
    exp_pop = req_at_stop && (m_q.size() > 0) && !is_clr;
    if (exp_pop) m_digit = m_q.pop_front();
    if (is_clr) begin
      m_q.delete();
      m_ovf = 0;
    end else if (is_dig) begin
      if (m_q.size() < 4) m_q.push_back(int'(b) - 48);
      else m_ovf = 1;
    end
    if (bad_stop && m_errs < 15) m_errs++;
    @(posedge clk);
    #1;
    check("stop_edge.level", int'(fifo_level), m_q.size());
    check("stop_edge.valid", int'(digit_valid), int'(exp_pop));
    check("stop_edge.digit", int'(digit), m_digit);
    @(negedge clk);
    digit_req = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check_state("frame");
  endtask

  task automatic do_req();
    bit exp_v;
    exp_v = (m_q.size() > 0);
    if (exp_v) m_digit = m_q.pop_front();
    digit_req = 1'b1;
    @(posedge clk);
    #1;
    check("pop.valid", int'(digit_valid), int'(exp_v));
    check("pop.digit", int'(digit), m_digit);
    check("pop.level", int'(fifo_level), m_q.size());
    @(negedge clk);
    digit_req = 1'b0;
    @(posedge clk);
    #1;
    check("pop.valid_1cyc", int'(digit_valid), 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic [9:0] frame;
    rx        = 1'b1;
    digit_req = 1'b0;
    reset_n   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.digit", int'(digit), 0);
    check("rst.valid", int'(digit_valid), 0);
    check_state("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single digit then pop.
    send_byte(8'h35, 0, 0);
    do_req();

    // Fill past capacity, drain one beyond empty.
    send_byte(8'h31, 0, 0);
    send_byte(8'h32, 0, 0);
    send_byte(8'h33, 0, 0);
    send_byte(8'h34, 0, 0);
    send_byte(8'h39, 0, 0);
    repeat (5) do_req();

    // Non-digit bytes are ignored.
    send_byte(8'h41, 0, 0);
    send_byte(8'h0D, 0, 0);

    // Framing error, then a good byte.
    send_byte(8'h37, 1, 0);
    send_byte(8'h38, 0, 0);

    // Overflow then clear; clear coinciding with a request.
    send_byte(8'h33, 0, 0);
    send_byte(8'h36, 0, 0);
    send_byte(8'h30, 0, 0);
    send_byte(8'h31, 0, 0);
    send_byte(8'h23, 0, 1);
    do_req();

    // Push and pop together at empty, then at full.
    send_byte(8'h34, 0, 1);
    send_byte(8'h35, 0, 0);
    send_byte(8'h36, 0, 0);
    send_byte(8'h37, 0, 0);
    send_byte(8'h38, 0, 1);

    // One-cycle glitch on rx.
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_state("glitch");

    // Randomised traffic.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        7:       b = 8'h23;
        8, 9:    b = 8'($urandom_range(0, 255));
        default: b = 8'(8'h30 + $urandom_range(0, 9));
      endcase
      send_byte(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) do_req();
    end

    // Reset in the middle of a frame with a non-empty FIFO and non-zero digit.
    send_byte(8'h39, 0, 0);
    send_byte(8'h37, 0, 0);
    do_req();
    send_byte(8'h36, 0, 0);
    frame = {1'b1, 8'h34, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx = frame[5];
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    rx = 1'b1;
    check("midrst.digit", int'(digit), 0);
    check("midrst.valid", int'(digit_valid), 0);
    check_state("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h32, 0, 0);
    check("after_rst.level", int'(fifo_level), 1);
    do_req();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
